// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver running entirely in the system clock domain.
// Samples the keyboard clock/data lines and deframes 11-bit device-to-host frames.
// Decodes E0/F0 prefixes into key events, buffers them in an event FIFO and
// tracks the operating mode selected by configurable make codes.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   ps2_clk        raw keyboard clock line (asynchronous, sampled)
//   ps2_data       raw keyboard data line (asynchronous, sampled)
//   event_valid    FIFO non-empty
//   event_ready    consumer pop, effective only while event_valid is high
//   event_code     scan code at FIFO head
//   event_release  head event is a break
//   event_ext      head event carried the E0 prefix
//   mode           0 manual, 1 auto, 2 record
//   led            code of the most recent make event
//   frame_err      one-cycle pulse on bad start/parity/stop or timeout
//   overflow       one-cycle pulse when an event is dropped on a full FIFO
module ps2_kbd_rx #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic [7:0]  KEY_MANUAL     = 8'h35,
   parameter logic [7:0]  KEY_AUTO       = 8'h2D,
   parameter logic [7:0]  KEY_RECORD     = 8'h2C
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       event_valid,
   input  logic       event_ready,
   output logic [7:0] event_code,
   output logic       event_release,
   output logic       event_ext,
   output logic [1:0] mode,
   output logic [7:0] led,
   output logic       frame_err,
   output logic       overflow
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned EW = 10;
   localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [7:0] BYTE_EXT = 8'hE0;
   localparam logic [7:0] BYTE_REL = 8'hF0;
   localparam logic [7:0] LED_RESET = 8'hF0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
   logic [1:0] clk_sync_q;
   logic [1:0] data_sync_q;
   logic       clk_prev_q;
   logic       fall_c;
   logic       bit_c;

   // Two-flop synchronisers plus previous-value flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
         clk_prev_q  <= clk_sync_q[1];
      end
   end

   assign fall_c = clk_prev_q & ~clk_sync_q[1];
   assign bit_c  = data_sync_q[1];

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t          state_q;
   state_t          state_d;
   logic [2:0]      bit_cnt_q;
   logic [7:0]      shift_q;
   logic            par_err_q;
   logic [TW-1:0]   to_cnt_q;
   logic            timeout_c;
   logic            start_c;
   logic            shift_c;
   logic            par_c;
   logic            accept_c;
   logic            stop_bad_c;

   // Timeout only fires mid-frame and only when no edge arrives this cycle.
   assign timeout_c = (state_q != S_IDLE) && !fall_c && (to_cnt_q >= TO_LIMIT);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: every transition except timeout needs a falling edge.
   always_comb begin
      state_d = state_q;
      if (timeout_c) begin
         state_d = S_IDLE;
      end else if (fall_c) begin
         case (state_q)
            S_IDLE:   if (!bit_c) state_d = S_DATA;
            S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            S_PARITY: state_d = S_STOP;
            S_STOP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Output decode of the FSM into datapath strobes.
   always_comb begin
      start_c    = 1'b0;
      shift_c    = 1'b0;
      par_c      = 1'b0;
      accept_c   = 1'b0;
      stop_bad_c = 1'b0;
      if (fall_c) begin
         case (state_q)
            S_IDLE:   start_c    = ~bit_c;
            S_DATA:   shift_c    = 1'b1;
            S_PARITY: par_c      = 1'b1;
            S_STOP: begin
               accept_c   = bit_c & ~par_err_q;
               stop_bad_c = ~bit_c | par_err_q;
            end
            default: ;
         endcase
      end
   end

   // Frame datapath: shift register, bit counter, parity error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'd0;
         par_err_q <= 1'b0;
      end else begin
         if (start_c) begin
            bit_cnt_q <= 3'd0;
            par_err_q <= 1'b0;
         end
         if (shift_c) begin
            shift_q   <= {bit_c, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
         end
         // Odd parity: data bits plus parity bit must contain an odd number of ones.
         if (par_c) begin
            par_err_q <= ~((^shift_q) ^ bit_c);
         end
      end
   end

   // Inactivity counter: cleared on edges and held at zero while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
      end else if ((state_q == S_IDLE) || fall_c || timeout_c) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + TW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Accepted byte and error pulse
   // ------------------------------------------------------------------
   logic       byte_acc_q;
   logic [7:0] byte_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_acc_q <= 1'b0;
         byte_q     <= 8'd0;
         frame_err  <= 1'b0;
      end else begin
         byte_acc_q <= accept_c;
         if (accept_c) begin
            byte_q <= shift_q;
         end
         frame_err <= stop_bad_c | timeout_c;
      end
   end

   // ------------------------------------------------------------------
   // Byte decoder
   // ------------------------------------------------------------------
   logic ext_q;
   logic rel_q;
   logic is_ext_c;
   logic is_rel_c;
   logic push_req_c;

   assign is_ext_c   = (byte_q == BYTE_EXT);
   assign is_rel_c   = (byte_q == BYTE_REL);
   assign push_req_c = byte_acc_q & ~is_ext_c & ~is_rel_c;

   // Prefix flags; a discarded frame cancels any pending prefix.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_q <= 1'b0;
         rel_q <= 1'b0;
      end else if (frame_err) begin
         ext_q <= 1'b0;
         rel_q <= 1'b0;
      end else if (byte_acc_q) begin
         if (is_ext_c) begin
            ext_q <= 1'b1;
         end else if (is_rel_c) begin
            rel_q <= 1'b1;
         end else begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
         end
      end
   end

   // Mode and led follow make events at push time, even if the FIFO drops them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode <= 2'd0;
         led  <= LED_RESET;
      end else if (push_req_c && !rel_q) begin
         led <= byte_q;
         if (byte_q == KEY_MANUAL) begin
            mode <= 2'd0;
         end else if (byte_q == KEY_AUTO) begin
            mode <= 2'd1;
         end else if (byte_q == KEY_RECORD) begin
            mode <= 2'd2;
         end
      end
   end

   // ------------------------------------------------------------------
   // Event FIFO, entries are {ext, rel, code}
   // ------------------------------------------------------------------
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [CW-1:0] count_q;
   logic          full_c;
   logic          pop_c;
   logic          push_c;

   assign full_c = (count_q == FULL_CNT);
   assign pop_c  = event_valid & event_ready;
   // A pop in the same cycle frees the slot, so push is allowed even when full.
   assign push_c = push_req_c & (~full_c | pop_c);

   // Storage array and pointers; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push_req_c & full_c & ~pop_c;
         if (push_c) begin
            mem_q[wptr_q] <= {ext_q, rel_q, byte_q};
            wptr_q        <= wptr_q + AW'(1);
         end
         if (pop_c) begin
            rptr_q <= rptr_q + AW'(1);
         end
         case ({push_c, pop_c})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign event_valid = (count_q != '0);
   assign {event_ext, event_release, event_code} = mem_q[rptr_q];

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Second-generation PS/2 keyboard receiver. Runs entirely in the system clock domain; the keyboard's clock and data lines are sampled, not used as clocks.
- Deframes 11-bit device-to-host frames with start, parity and stop checking, plus an inactivity timeout.
- Decodes make, break (F0) and extended (E0) prefixes into key events and buffers them in a parametrised FIFO.
- Tracks the operating mode (manual/auto/record) from configurable key codes. Sits between the keyboard pins and the game/control logic.

Parameters:
- FIFO_DEPTH, 8: event FIFO entries. Power of 2, at least 2.
- TIMEOUT_CYCLES, 100000: clk cycles allowed between PS/2 falling edges inside a frame.
- KEY_MANUAL, 8'h35: make code that selects mode 0.
- KEY_AUTO, 8'h2D: make code that selects mode 1.
- KEY_RECORD, 8'h2C: make code that selects mode 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw keyboard clock line (asynchronous).
- ps2_data  in  1  raw keyboard data line (asynchronous).
- event_valid  out  1  FIFO non-empty.
- event_ready  in  1  consumer pop; effective only when event_valid is high.
- event_code  out  8  scan code at FIFO head.
- event_release  out  1  head event is a break (key released).
- event_ext  out  1  head event carried the E0 prefix.
- mode  out  2  0 manual, 1 auto, 2 record. Value 3 never occurs.
- led  out  8  code of the most recent make event.
- frame_err  out  1  one-cycle pulse on a bad start, parity, stop or timeout.
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
- Reset (async assert, sync release) sets the following:
  - Outputs: event_valid=0, event_code=0, event_release=0, event_ext=0, mode=0, led=8'hF0, frame_err=0, overflow=0.
  - Internals: FIFO empty, prefix flags clear, FSM in IDLE, synchronisers set to 1.
- Input conditioning: each of ps2_clk and ps2_data passes through its own 2-FF synchroniser. A falling edge is the synchronised clock going 1->0 between consecutive clk cycles. Data is sampled in the same cycle the edge is detected.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE. Every transition occurs only on a detected falling edge.
  - IDLE: a sampled 0 (start bit) moves to DATA with the bit counter at 0. A sampled 1 is ignored; the FSM stays in IDLE with no error.
  - DATA: shift bits in LSB first. After the 8th bit, move to PARITY.
  - PARITY: require odd parity over the 8 data bits plus the parity bit. On mismatch, latch an error flag and continue to STOP.
  - STOP: the sampled bit must be 1. If it is 1 and no error was flagged, the byte is accepted. Otherwise pulse frame_err and discard the byte. Return to IDLE in both cases.
  - Timeout: a counter resets on every falling edge. If it reaches TIMEOUT_CYCLES while the FSM is not IDLE, the FSM returns to IDLE, the partial frame is discarded and frame_err pulses. The counter is held at 0 in IDLE.
- Byte decoder, acting on each accepted byte:
  - E0 sets the ext flag.
  - F0 sets the rel flag.
  - Any other byte forms the event {ext, rel, byte}; both flags then clear.
  - E0 followed by F0 keeps both flags set.
  - A discarded frame clears both flags.
- Event push: an event is written to the FIFO on the clk edge after the byte is accepted. If the FIFO is already full at that edge, the event is dropped, overflow pulses, and the FIFO contents are unchanged.
- Latency: with the FIFO empty, event_valid rises 2 clk cycles after the cycle in which the stop-bit edge is detected.
- FIFO behaviour:
  - Head outputs are valid whenever event_valid is high.
  - A pop occurs on any cycle with event_valid and event_ready both high.
  - A simultaneous push and pop is allowed in every state, full included; occupancy is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Mode and led: updated for non-release events only, and at push time regardless of FIFO space.
  - code==KEY_MANUAL sets mode to 0; code==KEY_AUTO sets mode to 1; code==KEY_RECORD sets mode to 2. The mode keys apply whether or not the event is extended.
  - led takes the code of every make event.
  - Release events change neither mode nor led.
- A reset asserted mid-frame aborts the frame with no frame_err pulse.

Test Plan:
- Frame 0x1C (parity bit 0, stop 1) -> event_valid high 2 cycles after stop; code=1C, rel=0, ext=0; led=1C; mode stays 0.
- Sequence 0x2D, then F0 (parity 1), then 2D -> events {2D,0,0} then {2D,1,0}; mode=1 after the first event and still 1 after the release.
- Sequence E0 (parity 0), F0, 0x75 (parity 0) -> single event code=75, rel=1, ext=1; led unchanged.
- Frame 0x1C sent with parity bit 1, and a separate frame with stop bit 0 -> frame_err pulses once per frame, no event, FIFO unchanged.
- Stop ps2_clk toggling after 4 data bits for TIMEOUT_CYCLES -> frame_err pulse and FSM returns to IDLE; a following valid 0x2C frame yields mode=2.
- With event_ready=0, send FIFO_DEPTH+1 make codes -> FIFO holds the first 8 in order and overflow pulses once. Pulling event_ready high then drains all 8 in order, and event_valid goes low afterwards.
